// File: rtl/loop_counter_if.sv
// loop_counter_if: control/status bundle between the modexp controller and
// loop_counter. The controller side uses modport master, the counter uses slave.
// Optional feature macro: LOOP_CNTR_PRESCALE_EN adds the prescale field.
//
// Handshake semantics: there is no valid/ready pair. start is a level request
// that the counter takes only while idle (busy=0); the accept is visible as busy
// rising on the following edge. abort is a level sampled on every clock while
// busy=1 and ignored otherwise. tc and done are single-cycle event strobes.
interface loop_counter_if #(
    parameter int CNTR_WIDTH     = 6,
    parameter int PRESCALE_WIDTH = 4
);
    logic                      start;
    logic                      abort;
    logic [CNTR_WIDTH-1:0]     start_val;
    logic [CNTR_WIDTH-1:0]     end_val;
    logic                      down;
    logic                      mode_wrap;
`ifdef LOOP_CNTR_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] prescale;
`else
    // PRESCALE_WIDTH only sizes the prescale field; keep the parameter list
    // identical in both builds.
    if (PRESCALE_WIDTH < 1) begin : g_prescale_width_unused
    end
`endif
    logic                      busy;
    logic                      tc;
    logic                      done;
    logic [CNTR_WIDTH-1:0]     cntr_out;
    // Debug view of the counter FSM: 0 = IDLE, 1 = RUN.
    logic                      dbg_state;

    modport master (
        output start, abort, start_val, end_val, down, mode_wrap,
`ifdef LOOP_CNTR_PRESCALE_EN
        output prescale,
`endif
        input  busy, tc, done, cntr_out, dbg_state
    );

    modport slave (
        input  start, abort, start_val, end_val, down, mode_wrap,
`ifdef LOOP_CNTR_PRESCALE_EN
        input  prescale,
`endif
        output busy, tc, done, cntr_out, dbg_state
    );
endinterface

// File: rtl/loop_counter.sv
// loop_counter: start/stop loop counter for the modular-exponentiation datapath.
// Loads a start value, steps up or down once per tick until it equals the
// terminal value, then either stops with done (one-shot) or reloads (wrap).
// All arithmetic is modulo 2^CNTR_WIDTH, so any terminal value is reachable.
// Optional feature macro: LOOP_CNTR_PRESCALE_EN - a tick happens every
// prescale+1 clocks in RUN instead of every clock.
module loop_counter #(
    parameter int CNTR_WIDTH     = 6,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    loop_counter_if.slave   bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [CNTR_WIDTH-1:0] r_cntr;
    logic [CNTR_WIDTH-1:0] r_start_lat;
    logic [CNTR_WIDTH-1:0] r_end_lat;
    logic                  r_down;
    logic                  r_wrap;
    logic                  r_busy;
    logic                  r_tc;
    logic                  r_done;

    logic                  w_tick;
    logic                  w_at_end;
    logic [CNTR_WIDTH-1:0] w_cntr_step;

    // Terminal compare and the next stepped value are pure functions of the
    // latched run configuration, never of the live inputs.
    assign w_at_end    = (r_cntr == r_end_lat);
    assign w_cntr_step = r_down ? (r_cntr - CNT_ONE) : (r_cntr + CNT_ONE);

`ifdef LOOP_CNTR_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] r_ps_lat;
    logic [PRESCALE_WIDTH-1:0] r_ps_cnt;
    localparam logic [PRESCALE_WIDTH-1:0] PS_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    // A tick fires when the prescale counter has run prescale+1 clocks.
    assign w_tick = (r_ps_cnt == r_ps_lat);

    // Prescale divider: restarts on accept, abort and every tick (which
    // covers the terminal reload), free-runs between ticks in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps_lat <= '0;
            r_ps_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ps_lat <= bus.prescale;
                        r_ps_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (bus.abort || w_tick) begin
                        r_ps_cnt <= '0;
                    end else begin
                        r_ps_cnt <= r_ps_cnt + PS_ONE;
                    end
                end
                default: r_ps_cnt <= '0;
            endcase
        end
    end
`else
    // Without a prescaler every RUN clock is a tick.
    assign w_tick = 1'b1;

    if (PRESCALE_WIDTH < 1) begin : g_prescale_width_unused
    end
`endif

    // Control FSM with registered outputs: accept in IDLE, then abort,
    // terminal handling and stepping in RUN, in that priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cntr      <= '0;
            r_start_lat <= '0;
            r_end_lat   <= '0;
            r_down      <= 1'b0;
            r_wrap      <= 1'b0;
            r_busy      <= 1'b0;
            r_tc        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Event strobes default low so they last exactly one clock.
            r_tc   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cntr      <= bus.start_val;
                        r_start_lat <= bus.start_val;
                        r_end_lat   <= bus.end_val;
                        r_down      <= bus.down;
                        r_wrap      <= bus.mode_wrap;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        // Stop where we are; the count is left visible.
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        if (w_at_end) begin
                            r_tc <= 1'b1;
                            if (r_wrap) begin
                                r_cntr <= r_start_lat;
                            end else begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cntr <= w_cntr_step;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.tc        = r_tc;
    assign bus.done      = r_done;
    assign bus.cntr_out  = r_cntr;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_loop_counter.sv
// tb_loop_counter: randomized bench for loop_counter. The driver pushes the
// expected {busy,tc,done,cntr_out} for every clock into exp_q; a negedge
// monitor pops and compares. Expectations come from closed-form run arithmetic.
// Optional feature macro: LOOP_CNTR_PRESCALE_EN enables prescale stimulus.
module tb_loop_counter;
  localparam int W  = 6;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  loop_counter_if #(.CNTR_WIDTH(W), .PRESCALE_WIDTH(PW)) bus ();

  loop_counter #(.CNTR_WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [W+2:0] exp_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  string        test_name   = "reset";
  logic [W-1:0] last_cntr   = '0;

  // Monitor: one expected vector per clock, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W+2:0] e;
      logic [W+2:0] a;
      e = exp_q.pop_front();
      a = {bus.busy, bus.tc, bus.done, bus.cntr_out};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got busy=%b tc=%b done=%b cntr=%0d, expected busy=%b tc=%b done=%b cntr=%0d",
                 test_name, a[W+2], a[W+1], a[W], a[W-1:0], e[W+2], e[W+1], e[W], e[W-1:0]);
      end
    end
  end

  task automatic push(input bit b, input bit t, input bit d, input logic [W-1:0] c);
    exp_q.push_back({b, t, d, c});
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  // Direct check of the reset state, including the FSM debug view.
  task automatic check_reset();
    vectors++;
    if (bus.busy !== 1'b0 || bus.tc !== 1'b0 || bus.done !== 1'b0 ||
        bus.cntr_out !== '0 || bus.dbg_state !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b tc=%b done=%b cntr=%0d state=%b",
               bus.busy, bus.tc, bus.done, bus.cntr_out, bus.dbg_state);
    end
  endtask

  task automatic scramble_cfg();
    bus.start_val = W'($urandom);
    bus.end_val   = W'($urandom);
    bus.down      = 1'($urandom);
    bus.mode_wrap = 1'($urandom);
`ifdef LOOP_CNTR_PRESCALE_EN
    bus.prescale  = PW'($urandom);
`endif
  endtask

  // Idle clocks with random abort and garbage config: nothing may move.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.start = 1'b0;
      bus.abort = 1'($urandom_range(0, 1));
      scramble_cfg();
      clk_edge();
      push(1'b0, 1'b0, 1'b0, last_cntr);
    end
    bus.abort = 1'b0;
  endtask

  // One run from accept to its end. Edge j after accept has seen
  // t = j/(p+1) ticks; the run's pass length is n+1 ticks where
  // n = distance from start to end in the counting direction (mod 2^W).
  // abort_at/rst_at: edge index where abort/reset is applied, 0 = never.
  // spam: hold start high throughout RUN (must be ignored).
  task automatic run(input logic [W-1:0] sv, input logic [W-1:0] ev,
                     input bit dn, input bit wr, input int p,
                     input int abort_at, input int rst_at,
                     input int max_len, input bit spam);
    logic [W-1:0] diff;
    logic [W-1:0] c;
    logic [W-1:0] prev;
    int n, per, t, pos;
    bit tcx;
    diff = dn ? (sv - ev) : (ev - sv);
    n    = int'(diff);
    per  = p + 1;
    bus.start     = 1'b1;
    bus.abort     = 1'b0;
    bus.start_val = sv;
    bus.end_val   = ev;
    bus.down      = dn;
    bus.mode_wrap = wr;
`ifdef LOOP_CNTR_PRESCALE_EN
    bus.prescale  = PW'(p);
`endif
    clk_edge();
    push(1'b1, 1'b0, 1'b0, sv);
    prev = sv;
    last_cntr = sv;
    for (int j = 1; j <= max_len; j++) begin
      bus.start = spam ? 1'b1 : 1'($urandom_range(0, 1));
      bus.abort = (j == abort_at);
      rst       = (j == rst_at);
      scramble_cfg();
      clk_edge();
      if (j == rst_at) begin
        rst = 1'b0;
        push(1'b0, 1'b0, 1'b0, '0);
        last_cntr = '0;
        break;
      end
      if (j == abort_at) begin
        push(1'b0, 1'b0, 1'b0, prev);
        last_cntr = prev;
        break;
      end
      t = j / per;
      if (!wr && t == n + 1) begin
        push(1'b0, 1'b1, 1'b1, ev);
        last_cntr = ev;
        break;
      end
      pos = wr ? (t % (n + 1)) : t;
      c   = dn ? (sv - W'(pos)) : (sv + W'(pos));
      tcx = wr && (t > 0) && (pos == 0) && (j % per == 0);
      push(1'b1, tcx, 1'b0, c);
      prev = c;
      last_cntr = c;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    logic [W-1:0] sv, ev, diff;
    bit dn, wr;
    int p, len, ab, rs;
    int wait_cnt;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.start_val = '0;
    bus.end_val = '0;
    bus.down = 1'b0;
    bus.mode_wrap = 1'b0;
`ifdef LOOP_CNTR_PRESCALE_EN
    bus.prescale = '0;
`endif
    rst = 1'b1;
    clk_edge();
    push(1'b0, 1'b0, 1'b0, '0);
    clk_edge();
    push(1'b0, 1'b0, 1'b0, '0);
    check_reset();
    rst = 1'b0;
    idle_cycles(2);

    test_name = "oneshot_0_to_3";
    run(6'd0, 6'd3, 1'b0, 1'b0, 0, 0, 0, 10, 1'b0);
    idle_cycles(2);

    test_name = "wrap_down_5_to_2";
    run(6'd5, 6'd2, 1'b1, 1'b1, 0, 14, 0, 14, 1'b0);
    idle_cycles(2);

    test_name = "oneshot_wrap_62_to_1";
    run(6'd62, 6'd1, 1'b0, 1'b0, 0, 0, 0, 10, 1'b0);
    idle_cycles(2);

    test_name = "oneshot_equal_7";
    run(6'd7, 6'd7, 1'b0, 1'b0, 0, 0, 0, 5, 1'b0);
    idle_cycles(2);

    test_name = "abort_with_start";
    run(6'd0, 6'd9, 1'b0, 1'b0, 0, 3, 0, 15, 1'b1);
    idle_cycles(3);

    test_name = "reset_mid_run";
    run(6'd0, 6'd9, 1'b0, 1'b0, 0, 0, 5, 15, 1'b0);
    idle_cycles(2);

`ifdef LOOP_CNTR_PRESCALE_EN
    test_name = "prescale_2";
    run(6'd0, 6'd2, 1'b0, 1'b0, 2, 0, 0, 12, 1'b0);
    idle_cycles(2);
`endif

    test_name = "random";
    for (int r = 0; r < 40; r++) begin
      sv = W'($urandom);
      ev = W'($urandom);
      dn = 1'($urandom);
      wr = 1'($urandom);
`ifdef LOOP_CNTR_PRESCALE_EN
      p = $urandom_range(0, 3);
`else
      p = 0;
`endif
      diff = dn ? (sv - ev) : (ev - sv);
      rs = 0;
      ab = 0;
      if (wr) begin
        len = $urandom_range(5, 120);
        ab  = len;
      end else begin
        len = (int'(diff) + 1) * (p + 1) + 2;
        if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, len);
      end
      if ($urandom_range(0, 7) == 0) rs = $urandom_range(1, len);
      run(sv, ev, dn, wr, p, ab, rs, len, 1'b0);
      idle_cycles($urandom_range(1, 3));
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d expected vectors never compared", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule
